// File: rtl/wb_arbiter_pkg.sv
// Shared widths and write-back source indices for the integer register file writer.
// Also holds the pointer-width helper used by the arbiters.
`ifndef WB_ARBITER_DEFS
`define WB_ARBITER_DEFS
`define LEN_WORD 32
`define LEN_REG_ADDR 5
`define NUM_REG 32
`define NUM_WB_SRC 3
`define WB_SRC_ALU 0
`define WB_SRC_MEM 1
`define WB_SRC_FPU 2
`endif

package wb_arbiter_pkg;

    localparam int WB_SRC_ALU = `WB_SRC_ALU;
    localparam int WB_SRC_MEM = `WB_SRC_MEM;
    localparam int WB_SRC_FPU = `WB_SRC_FPU;

    // A lone requester still needs a 1-bit pointer to keep ports legal.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant searching upward from ptr_i.
// Reusable for any small requester set, e.g. the memory-port arbiter.
module rr_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] ptr_nxt_o
);

    logic found;
    int   idx;

    always_comb begin
        gnt_o     = '0;
        ptr_nxt_o = ptr_i;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_nxt_o  = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-side master: one result slot per execution unit,
// round-robin drained into a registered single write port.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int LEN_REG  = `LEN_WORD,
    parameter int NUM_SRC  = `NUM_WB_SRC,
    parameter int LEN_ADDR = `LEN_REG_ADDR
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC*LEN_ADDR-1:0]  src_rd,
    input  logic [NUM_SRC*LEN_REG-1:0]   src_data,
    output logic [NUM_SRC-1:0]           src_ready,
    output logic                         wr_en,
    output logic [LEN_ADDR-1:0]          wr_addr,
    output logic [LEN_REG-1:0]           wr_data,
    output logic                         idle
);

    localparam int PW = ptr_width(NUM_SRC);

    logic [NUM_SRC-1:0]  slot_valid_q, slot_valid_d;
    logic [LEN_ADDR-1:0] slot_rd_q   [NUM_SRC];
    logic [LEN_ADDR-1:0] slot_rd_d   [NUM_SRC];
    logic [LEN_REG-1:0]  slot_data_q [NUM_SRC];
    logic [LEN_REG-1:0]  slot_data_d [NUM_SRC];

    logic [PW-1:0]       rr_ptr_q, rr_ptr_d, ptr_nxt;
    logic [NUM_SRC-1:0]  grant, load;

    logic                wr_en_q, wr_en_d;
    logic [LEN_ADDR-1:0] wr_addr_q, wr_addr_d;
    logic [LEN_REG-1:0]  wr_data_q, wr_data_d;

    rr_arbiter #(
        .N  (NUM_SRC),
        .PW (PW)
    ) u_rr (
        .req_i     (slot_valid_q),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (grant),
        .ptr_nxt_o (ptr_nxt)
    );

    // A draining slot can accept in the same cycle, keeping one write per cycle.
    assign src_ready = {NUM_SRC{rstn}} & (~slot_valid_q | grant);

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_rd_d    = slot_rd_q;
        slot_data_d  = slot_data_q;
        load         = '0;
        wr_en_d      = |grant;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rr_ptr_d     = (|grant) ? ptr_nxt : rr_ptr_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            // Results aimed at x0 are swallowed at the handshake.
            load[i] = src_valid[i] & src_ready[i]
                    & (|src_rd[i*LEN_ADDR +: LEN_ADDR]);
            if (grant[i]) begin
                wr_addr_d       = slot_rd_q[i];
                wr_data_d       = slot_data_q[i];
                slot_valid_d[i] = 1'b0;
            end
            if (load[i]) begin
                slot_valid_d[i] = 1'b1;
                slot_rd_d[i]    = src_rd[i*LEN_ADDR +: LEN_ADDR];
                slot_data_d[i]  = src_data[i*LEN_REG +: LEN_REG];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            slot_valid_q <= '0;
            rr_ptr_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                slot_rd_q[i]   <= '0;
                slot_data_q[i] <= '0;
            end
        end else begin
            slot_valid_q <= slot_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                slot_rd_q[i]   <= slot_rd_d[i];
                slot_data_q[i] <= slot_data_d[i];
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign idle    = ~|slot_valid_q & ~wr_en_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, latency, x0 drop, streaming,
// fairness and mid-operation reset, all with hand-derived expectations.
module tb_wb_arbiter;

    logic        clk;
    logic        rstn;
    logic [2:0]  src_valid;
    logic [14:0] src_rd;
    logic [95:0] src_data;
    logic [2:0]  src_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        idle;

    int checks;
    int failures;

    wb_arbiter dut (
        .clk       (clk),
        .rstn      (rstn),
        .src_valid (src_valid),
        .src_rd    (src_rd),
        .src_data  (src_data),
        .src_ready (src_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v,
                           input logic [4:0] rd, input logic [31:0] d);
        src_valid[i]       = v;
        src_rd[i*5 +: 5]   = rd;
        src_data[i*32 +: 32] = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    logic [2:0]  exp_rdy;
    logic [2:0]  acc;
    int          k [3];
    int          s;
    int          n;

    initial begin
        checks    = 0;
        failures  = 0;
        rstn      = 1'b0;
        src_valid = '0;
        src_rd    = '0;
        src_data  = '0;

        // Reset held with all sources requesting
        set_src(0, 1'b1, 5'd1, 32'hA0);
        set_src(1, 1'b1, 5'd2, 32'hA1);
        set_src(2, 1'b1, 5'd3, 32'hA2);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_ready", 32'(src_ready), 32'h0);
            chk("rst_wr_en", 32'(wr_en), 32'h0);
        end
        chk("rst_idle", 32'(idle), 32'h1);
        chk("rst_wr_addr", 32'(wr_addr), 32'h0);
        chk("rst_wr_data", wr_data, 32'h0);
        rstn = 1'b1;
        #1;
        chk("s1_ready_all", 32'(src_ready), 32'h7);
        tick();
        src_valid = '0;
        chk("s1_e0_wr_en", 32'(wr_en), 32'h0);
        chk("s1_e0_idle", 32'(idle), 32'h0);
        tick();
        chk("s1_e1_wr_en", 32'(wr_en), 32'h1);
        chk("s1_e1_addr", 32'(wr_addr), 32'd1);
        chk("s1_e1_data", wr_data, 32'hA0);
        tick();
        chk("s1_e2_addr", 32'(wr_addr), 32'd2);
        chk("s1_e2_data", wr_data, 32'hA1);
        tick();
        chk("s1_e3_addr", 32'(wr_addr), 32'd3);
        chk("s1_e3_data", wr_data, 32'hA2);
        tick();
        chk("s1_e4_wr_en", 32'(wr_en), 32'h0);
        chk("s1_e4_idle", 32'(idle), 32'h1);

        // All sources streaming: round-robin 1,2,3 from pointer 0
        for (int i = 0; i < 3; i++) begin
            k[i] = 0;
            set_src(i, 1'b1, 5'(i + 1), (i << 16) | k[i]);
        end
        exp_rdy = 3'b111;
        for (int c = 0; c < 9; c++) begin
            chk("s4_ready", 32'(src_ready), 32'(exp_rdy));
            acc = exp_rdy;
            tick();
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) k[i]++;
                set_src(i, 1'b1, 5'(i + 1), (i << 16) | k[i]);
            end
            if (c == 0) begin
                chk("s4_first_wr_en", 32'(wr_en), 32'h0);
            end else begin
                s = (c - 1) % 3;
                chk("s4_wr_en", 32'(wr_en), 32'h1);
                chk("s4_addr", 32'(wr_addr), 32'(s + 1));
                chk("s4_data", wr_data, 32'((s << 16) | ((c - 1) / 3)));
            end
            exp_rdy = 3'(1 << (c % 3));
        end
        src_valid = '0;
        n = 0;
        while (!idle && n < 12) begin
            tick();
            n++;
        end
        chk("s4_drain_idle", 32'(idle), 32'h1);

        // Single source 0: accept-to-commit latency
        set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        chk("s2_ready0", 32'(src_ready[0]), 32'h1);
        tick();
        src_valid = '0;
        chk("s2_e0_wr_en", 32'(wr_en), 32'h0);
        tick();
        chk("s2_e1_wr_en", 32'(wr_en), 32'h1);
        chk("s2_e1_addr", 32'(wr_addr), 32'd5);
        chk("s2_e1_data", wr_data, 32'hDEADBEEF);
        tick();
        chk("s2_e2_wr_en", 32'(wr_en), 32'h0);
        chk("s2_e2_idle", 32'(idle), 32'h1);

        // Source 1: x0 result dropped, then a real one
        set_src(1, 1'b1, 5'd0, 32'h1234);
        #1;
        chk("s3_ready_x0", 32'(src_ready[1]), 32'h1);
        tick();
        chk("s3_x0_wr_en", 32'(wr_en), 32'h0);
        chk("s3_x0_idle", 32'(idle), 32'h1);
        set_src(1, 1'b1, 5'd7, 32'h55);
        #1;
        chk("s3_ready_r7", 32'(src_ready[1]), 32'h1);
        tick();
        src_valid = '0;
        chk("s3_e1_wr_en", 32'(wr_en), 32'h0);
        chk("s3_e1_idle", 32'(idle), 32'h0);
        tick();
        chk("s3_wr_en", 32'(wr_en), 32'h1);
        chk("s3_addr", 32'(wr_addr), 32'd7);
        chk("s3_data", wr_data, 32'h55);
        tick();
        chk("s3_after_wr_en", 32'(wr_en), 32'h0);
        chk("s3_after_idle", 32'(idle), 32'h1);

        // Source 2 back-to-back, no bubbles
        for (int j = 0; j < 8; j++) begin
            set_src(2, 1'b1, 5'd9, 32'(j));
            #1;
            chk("s5_ready2", 32'(src_ready[2]), 32'h1);
            tick();
            if (j > 0) begin
                chk("s5_wr_en", 32'(wr_en), 32'h1);
                chk("s5_addr", 32'(wr_addr), 32'd9);
                chk("s5_data", wr_data, 32'(j - 1));
            end
        end
        src_valid = '0;
        tick();
        chk("s5_last_wr_en", 32'(wr_en), 32'h1);
        chk("s5_last_data", wr_data, 32'd7);
        tick();
        chk("s5_end_wr_en", 32'(wr_en), 32'h0);

        // Mid-operation reset must rewind the pointer and drop slots
        set_src(0, 1'b1, 5'd4, 32'hC0);
        set_src(1, 1'b1, 5'd5, 32'hC1);
        set_src(2, 1'b1, 5'd6, 32'hC2);
        tick();
        src_valid = '0;
        tick();
        chk("s6_pre_wr_en", 32'(wr_en), 32'h1);
        chk("s6_pre_addr", 32'(wr_addr), 32'd4);
        rstn = 1'b0;
        #1;
        chk("s6_rst_ready", 32'(src_ready), 32'h0);
        tick();
        chk("s6_rst_wr_en", 32'(wr_en), 32'h0);
        chk("s6_rst_idle", 32'(idle), 32'h1);
        rstn = 1'b1;
        #1;
        chk("s6_post_ready", 32'(src_ready), 32'h7);
        set_src(0, 1'b1, 5'd1, 32'hD0);
        set_src(1, 1'b1, 5'd2, 32'hD1);
        set_src(2, 1'b1, 5'd3, 32'hD2);
        tick();
        src_valid = '0;
        chk("s6_e0_wr_en", 32'(wr_en), 32'h0);
        tick();
        chk("s6_first_wr_en", 32'(wr_en), 32'h1);
        chk("s6_first_addr", 32'(wr_addr), 32'd1);
        chk("s6_first_data", wr_data, 32'hD0);
        tick();
        chk("s6_second_addr", 32'(wr_addr), 32'd2);
        tick();
        chk("s6_third_addr", 32'(wr_addr), 32'd3);
        tick();
        chk("s6_end_idle", 32'(idle), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
